// File: rtl/dual_port_ram_param_if.sv
// dual_port_ram_param_if: write/read request and response bundle for dual_port_ram_param
interface dual_port_ram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int BE_W = DATA_W / 8;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              rd_err;
  logic              wr_err;
  logic              init_busy;
  modport master (
    output wr_en, wr_addr, wr_be, data_in, rd_en, rd_addr,
    input  data_out, rd_valid, rd_err, wr_err, init_busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_be, data_in, rd_en, rd_addr,
    output data_out, rd_valid, rd_err, wr_err, init_busy
  );
endinterface

// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: parametrised 1W/1R RAM with byte enables, range checks and zero-init sweep.
// Define DPRAM_BYPASS_EN for write-first collision data (read-first otherwise).
module dual_port_ram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1,
  parameter int BE_W     = DATA_W / 8
) (
  input logic clk,
  input logic rst,
  dual_port_ram_param_if.slave bus
);
  typedef enum logic {INIT, READY} state_t;
  localparam logic [ADDR_W:0] DEP = (ADDR_W + 1)'(DEPTH);
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old, rd_word, d1;
  logic              wr_oob, rd_oob, wr_ok, rd_ok, v1, e1;
  always_comb begin
    wr_oob = {1'b0, bus.wr_addr} >= DEP;
    rd_oob = {1'b0, bus.rd_addr} >= DEP;
    wr_ok  = state == READY && bus.wr_en && !wr_oob;
    rd_ok  = state == READY && bus.rd_en;
    old    = rd_oob ? '0 : mem[bus.rd_addr];
    rd_word = old;
`ifdef DPRAM_BYPASS_EN
    if (wr_ok && bus.wr_addr == bus.rd_addr)
      for (int i = 0; i < BE_W; i++)
        rd_word[8*i +: 8] = bus.wr_be[i] ? bus.data_in[8*i +: 8] : old[8*i +: 8];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      ptr        <= '0;
      v1         <= 1'b0;
      e1         <= 1'b0;
      d1         <= '0;
      bus.wr_err <= 1'b0;
    end else begin
      v1         <= rd_ok;
      e1         <= rd_ok && rd_oob;
      bus.wr_err <= state == READY && bus.wr_en && wr_oob;
      if (rd_ok) d1 <= rd_word;
      if (state == INIT) begin
        ptr <= ptr + 1'b1;
        if ({1'b0, ptr} == DEP - 1'b1) state <= READY;
      end
    end
  end
  // storage carries no reset; the INIT sweep zeroes it instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[ptr] <= '0;
      else
        for (int i = 0; i < BE_W; i++)
          if (wr_ok && bus.wr_be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
    end
  end
  assign bus.init_busy = state == INIT;
  if (READ_LAT == 2) begin : g_lat2
    logic              v2, e2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        e2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        if (v1) d2 <= d1;
      end
    end
    assign bus.rd_valid = v2;
    assign bus.rd_err   = e2;
    assign bus.data_out = d2;
  end else begin : g_lat1
    assign bus.rd_valid = v1;
    assign bus.rd_err   = e1;
    assign bus.data_out = d1;
  end
endmodule
